// File: rtl/finder_scan_if.sv
// Bundle between finder_scan, its frame buffer and the downstream cross stage.
// The slave side is the scanner; the master side drives start/pixel data.
interface finder_scan_if #(
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 480
) ();
  logic              start_scan;
  logic              pixel_reading;
  logic [19:0]       address_reading;
  logic [WIDTH-1:0]  horz_patterns;
  logic [HEIGHT-1:0] vert_patterns;
  logic              patterns_valid;
  logic              busy;

  modport master (
    output start_scan, pixel_reading,
    input  address_reading, horz_patterns, vert_patterns, patterns_valid, busy
  );

  modport slave (
    input  start_scan, pixel_reading,
    output address_reading, horz_patterns, vert_patterns, patterns_valid, busy
  );
endinterface

// File: rtl/finder_scan.sv
// Raster-scans the binarized frame row-major then column-major, running a 1:1:3:1:1
// run-length detector per line and marking the centre of every finder-pattern hit.
module finder_scan #(
  parameter int HEIGHT       = 480,
  parameter int WIDTH        = 480,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  finder_scan_if.slave bus
);
  localparam int MAXDIM = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int POS_W  = $clog2(MAXDIM);
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  typedef enum logic [2:0] {
    IDLE, ROW_SCAN, ROW_DRAIN, COL_SCAN, COL_DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             col;
    logic             eol;
    logic [POS_W-1:0] pos;
  } meta_t;

  state_t              state_q, state_d;
  logic [19:0]         addr_q, addr_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [7:0]          drain_q, drain_d;
  logic                startAccept;
  meta_t               push, tap;
  meta_t               pipe_q [READ_LATENCY];

  logic                colour_q, colour_d;
  logic [8:0]          runLen_q, runLen_d;
  logic [POS_W-1:0]    runStart_q, runStart_d;
  logic [4:0][8:0]     runs_q, runs_d;
  logic [4:0]          cols_q, cols_d;
  logic [4:0][POS_W-1:0] starts_q, starts_d;
  logic                hit;
  logic [POS_W-1:0]    centre;
  logic [WIDTH-1:0]    horz_q;
  logic [HEIGHT-1:0]   vert_q;

  // Runs are r0..r4 with r4 newest; colour bit 1 = white, so B,W,B,W,B reads 5'b01010.
  function automatic logic hitTest(input logic [4:0][8:0] r, input logic [4:0] c);
    logic [12:0] s13;
    logic [12:0] s3;
    logic        ok;
    s13 = 13'(11'(r[0]) + 11'(r[1]) + 11'(r[3]) + 11'(r[4]));
    s3  = s13 * 13'd3;
    ok  = (c == 5'b01010);
    for (int i = 0; i < 5; i++) begin
      if (r[i] == 9'd0) ok = 1'b0;
      if (i != 2 && ((13'(r[i]) * 13'd8 < s13) || (13'(r[i]) * 13'd8 > s3))) ok = 1'b0;
    end
    if ((13'(r[2]) * 13'd2 < s13) || (13'(r[2]) > s13)) ok = 1'b0;
    return ok;
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Address generator: one request per scan cycle, address held through the drains.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    x_d         = x_q;
    y_d         = y_q;
    drain_d     = drain_q;
    push        = '0;
    startAccept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_scan) begin
          startAccept = 1'b1;
          state_d     = ROW_SCAN;
          addr_d      = '0;
          x_d         = '0;
          y_d         = '0;
        end
      end
      ROW_SCAN: begin
        push.valid = 1'b1;
        push.pos   = POS_W'(x_q);
        push.eol   = (x_q == XW'(WIDTH - 1));
        if (push.eol && y_q == YW'(HEIGHT - 1)) begin
          state_d = ROW_DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 20'd1;
          if (push.eol) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ROW_DRAIN: begin
        if (drain_q == 8'(READ_LATENCY)) begin
          state_d = COL_SCAN;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      COL_SCAN: begin
        push.valid = 1'b1;
        push.col   = 1'b1;
        push.pos   = POS_W'(y_q);
        push.eol   = (y_q == YW'(HEIGHT - 1));
        if (push.eol && x_q == XW'(WIDTH - 1)) begin
          state_d = COL_DRAIN;
          drain_d = '0;
        end else if (push.eol) begin
          y_d    = '0;
          x_d    = x_q + XW'(1);
          addr_d = 20'(x_q) + 20'd1;
        end else begin
          y_d    = y_q + YW'(1);
          addr_d = addr_q + 20'(WIDTH);
        end
      end
      COL_DRAIN: begin
        if (drain_q == 8'(READ_LATENCY)) begin
          state_d = DONE;
          addr_d  = '0;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tap = pipe_q[READ_LATENCY-1];

  // Run-length detector; the end-of-line pixel may close two runs in one update.
  always_comb begin
    colour_d   = colour_q;
    runLen_d   = runLen_q;
    runStart_d = runStart_q;
    runs_d     = runs_q;
    cols_d     = cols_q;
    starts_d   = starts_q;
    hit        = 1'b0;
    centre     = '0;
    if (startAccept) begin
      colour_d = 1'b1;
      runLen_d = '0;
      runs_d   = '0;
      cols_d   = '1;
      starts_d = '0;
    end else if (tap.valid) begin
      if (runLen_q != 9'd0 && bus.pixel_reading != colour_q) begin
        runs_d   = {runLen_q, runs_d[4:1]};
        cols_d   = {colour_q, cols_d[4:1]};
        starts_d = {runStart_q, starts_d[4:1]};
        if (!colour_q && hitTest(runs_d, cols_d)) begin
          hit    = 1'b1;
          centre = starts_d[2] + POS_W'(runs_d[2] >> 1);
        end
        colour_d   = bus.pixel_reading;
        runLen_d   = 9'd1;
        runStart_d = tap.pos;
      end else begin
        colour_d = bus.pixel_reading;
        runLen_d = runLen_q + 9'd1;
        if (runLen_q == 9'd0) runStart_d = tap.pos;
      end
      if (tap.eol) begin
        runs_d   = {runLen_d, runs_d[4:1]};
        cols_d   = {colour_d, cols_d[4:1]};
        starts_d = {runStart_d, starts_d[4:1]};
        if (!colour_d && hitTest(runs_d, cols_d)) begin
          hit    = 1'b1;
          centre = starts_d[2] + POS_W'(runs_d[2] >> 1);
        end
        colour_d = 1'b1;
        runLen_d = '0;
        runs_d   = '0;
        cols_d   = '1;
        starts_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      drain_q    <= '0;
      colour_q   <= 1'b1;
      runLen_q   <= '0;
      runStart_q <= '0;
      runs_q     <= '0;
      cols_q     <= '1;
      starts_q   <= '0;
      horz_q     <= '0;
      vert_q     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      drain_q    <= drain_d;
      colour_q   <= colour_d;
      runLen_q   <= runLen_d;
      runStart_q <= runStart_d;
      runs_q     <= runs_d;
      cols_q     <= cols_d;
      starts_q   <= starts_d;
      pipe_q[0]  <= push;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      if (startAccept) begin
        horz_q <= '0;
        vert_q <= '0;
      end else if (hit) begin
        if (tap.col) vert_q[centre[YW-1:0]] <= 1'b1;
        else         horz_q[centre[XW-1:0]] <= 1'b1;
      end
    end
  end

  assign bus.address_reading = addr_q;
  assign bus.horz_patterns   = horz_q;
  assign bus.vert_patterns   = vert_q;
  assign bus.patterns_valid  = (state_q == DONE);
  assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_finder_scan.sv
// Directed bench for finder_scan on a 32x32 frame with a two-cycle frame-buffer model.
module tb_finder_scan;
  localparam int W        = 32;
  localparam int H        = 32;
  localparam int L        = 2;
  localparam int N        = W * H;
  localparam int DONE_CYC = 2 * N + 2 * L + 3;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int          validCount;
  int          validCycle;
  int          busyBad;
  logic [19:0] addrTrace [0:DONE_CYC+10];

  finder_scan_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  finder_scan #(.HEIGHT(H), .WIDTH(W), .READ_LATENCY(L)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Frame buffer: data for the address seen on cycle t appears on cycle t+2.
  logic        frame [N];
  logic [19:0] a0 = '0;
  logic [19:0] a1 = '0;
  always @(posedge clk_in) begin
    a0 <= bus.address_reading;
    a1 <= a0;
  end
  assign bus.pixel_reading = (a1 < 20'(N)) ? frame[a1[9:0]] : 1'b1;

  task automatic clearFrame();
    for (int i = 0; i < N; i++) frame[i] = 1'b1;
  endtask

  task automatic setRow(input int y, input int x0, input int len);
    for (int i = 0; i < len; i++) frame[y * W + x0 + i] = 1'b0;
  endtask

  task automatic setCol(input int x, input int y0, input int len);
    for (int i = 0; i < len; i++) frame[(y0 + i) * W + x] = 1'b0;
  endtask

  // Leaves the bench just after the edge that sampled start, i.e. in cycle 1.
  task automatic startPulse();
    @(negedge clk_in);
    bus.start_scan = 1'b1;
    @(posedge clk_in);
    #1 bus.start_scan = 1'b0;
  endtask

  task automatic runScan(input int pulseAt);
    startPulse();
    validCount = 0;
    validCycle = -1;
    busyBad    = 0;
    for (int c = 1; c <= DONE_CYC + 5; c++) begin
      @(negedge clk_in);
      addrTrace[c] = bus.address_reading;
      if (bus.patterns_valid === 1'b1) begin
        validCount++;
        if (validCycle < 0) validCycle = c;
      end
      if (bus.busy !== (c <= DONE_CYC)) busyBad++;
      bus.start_scan = (c == pulseAt);
      @(posedge clk_in);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    checks++; if (bus.address_reading !== 20'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus.address_reading); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.patterns_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.patterns_valid); end
    checks++; if (bus.horz_patterns !== '0) begin errors++; $display("[TB] FAIL reset_horz: got %h expected 0", bus.horz_patterns); end
    checks++; if (bus.vert_patterns !== '0) begin errors++; $display("[TB] FAIL reset_vert: got %h expected 0", bus.vert_patterns); end
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_all_white();
    clearFrame();
    runScan(0);
    checks++; if (validCount != 1) begin errors++; $display("[TB] FAIL white_valid_count: got %0d expected 1", validCount); end
    checks++; if (validCycle != 2055) begin errors++; $display("[TB] FAIL white_valid_cycle: got %0d expected 2055", validCycle); end
    checks++; if (busyBad != 0) begin errors++; $display("[TB] FAIL white_busy_window: got %0d bad cycles expected 0", busyBad); end
    checks++; if (bus.horz_patterns !== '0) begin errors++; $display("[TB] FAIL white_horz: got %h expected 0", bus.horz_patterns); end
    checks++; if (bus.vert_patterns !== '0) begin errors++; $display("[TB] FAIL white_vert: got %h expected 0", bus.vert_patterns); end
    checks++; if (addrTrace[1] !== 20'd0) begin errors++; $display("[TB] FAIL addr_c1: got %0d expected 0", addrTrace[1]); end
    checks++; if (addrTrace[2] !== 20'd1) begin errors++; $display("[TB] FAIL addr_c2: got %0d expected 1", addrTrace[2]); end
    checks++; if (addrTrace[1024] !== 20'd1023) begin errors++; $display("[TB] FAIL addr_c1024: got %0d expected 1023", addrTrace[1024]); end
    checks++; if (addrTrace[1027] !== 20'd1023) begin errors++; $display("[TB] FAIL addr_drain_hold: got %0d expected 1023", addrTrace[1027]); end
    checks++; if (addrTrace[1028] !== 20'd0) begin errors++; $display("[TB] FAIL addr_col_start: got %0d expected 0", addrTrace[1028]); end
    checks++; if (addrTrace[1029] !== 20'd32) begin errors++; $display("[TB] FAIL addr_col_step: got %0d expected 32", addrTrace[1029]); end
    checks++; if (addrTrace[1060] !== 20'd1) begin errors++; $display("[TB] FAIL addr_col_wrap: got %0d expected 1", addrTrace[1060]); end
    checks++; if (addrTrace[2051] !== 20'd1023) begin errors++; $display("[TB] FAIL addr_col_last: got %0d expected 1023", addrTrace[2051]); end
    checks++; if (addrTrace[2056] !== 20'd0) begin errors++; $display("[TB] FAIL addr_idle: got %0d expected 0", addrTrace[2056]); end
  endtask

  task automatic test_row_pattern();
    logic [W-1:0] expH;
    clearFrame();
    setRow(5, 3, 1); setRow(5, 5, 3); setRow(5, 9, 1);
    runScan(0);
    expH = '0; expH[6] = 1'b1;
    checks++; if (bus.horz_patterns !== expH) begin errors++; $display("[TB] FAIL row_horz: got %h expected %h", bus.horz_patterns, expH); end
    checks++; if (bus.vert_patterns !== '0) begin errors++; $display("[TB] FAIL row_vert: got %h expected 0", bus.vert_patterns); end
  endtask

  task automatic test_col_pattern();
    logic [H-1:0] expV;
    clearFrame();
    setCol(20, 3, 1); setCol(20, 5, 3); setCol(20, 9, 1);
    runScan(0);
    expV = '0; expV[6] = 1'b1;
    checks++; if (bus.vert_patterns !== expV) begin errors++; $display("[TB] FAIL col_vert: got %h expected %h", bus.vert_patterns, expV); end
    checks++; if (bus.horz_patterns !== '0) begin errors++; $display("[TB] FAIL col_horz: got %h expected 0", bus.horz_patterns); end
  endtask

  task automatic test_finder();
    logic [W-1:0] expH;
    logic [H-1:0] expV;
    clearFrame();
    for (int my = 0; my < 7; my++)
      for (int mx = 0; mx < 7; mx++)
        if (mx == 0 || mx == 6 || my == 0 || my == 6 || (mx >= 2 && mx <= 4 && my >= 2 && my <= 4))
          for (int d = 0; d < 2; d++) setRow(10 + 2 * my + d, 10 + 2 * mx, 2);
    runScan(0);
    expH = '0; expH[17] = 1'b1;
    expV = '0; expV[17] = 1'b1;
    checks++; if (bus.horz_patterns !== expH) begin errors++; $display("[TB] FAIL finder_horz: got %h expected %h", bus.horz_patterns, expH); end
    checks++; if (bus.vert_patterns !== expV) begin errors++; $display("[TB] FAIL finder_vert: got %h expected %h", bus.vert_patterns, expV); end
  endtask

  task automatic test_ratio_limits();
    logic [W-1:0] expH;
    clearFrame();
    setRow(2, 2, 1); setRow(2, 4, 6); setRow(2, 11, 1);
    runScan(0);
    checks++; if (bus.horz_patterns !== '0) begin errors++; $display("[TB] FAIL ratio_wide_horz: got %h expected 0", bus.horz_patterns); end
    checks++; if (bus.vert_patterns !== '0) begin errors++; $display("[TB] FAIL ratio_wide_vert: got %h expected 0", bus.vert_patterns); end
    clearFrame();
    setRow(2, 2, 1); setRow(2, 4, 4); setRow(2, 9, 1);
    runScan(0);
    expH = '0; expH[6] = 1'b1;
    checks++; if (bus.horz_patterns !== expH) begin errors++; $display("[TB] FAIL ratio_edge_horz: got %h expected %h", bus.horz_patterns, expH); end
  endtask

  task automatic test_line_end();
    logic [W-1:0] expH;
    clearFrame();
    setRow(7, 25, 1); setRow(7, 27, 3); setRow(7, 31, 1);
    runScan(0);
    expH = '0; expH[28] = 1'b1;
    checks++; if (bus.horz_patterns !== expH) begin errors++; $display("[TB] FAIL eol_horz: got %h expected %h", bus.horz_patterns, expH); end
    checks++; if (bus.vert_patterns !== '0) begin errors++; $display("[TB] FAIL eol_vert: got %h expected 0", bus.vert_patterns); end
    clearFrame();
    setRow(3, 28, 1); setRow(3, 30, 2); setRow(4, 0, 1); setRow(4, 2, 1);
    runScan(0);
    checks++; if (bus.horz_patterns !== '0) begin errors++; $display("[TB] FAIL split_horz: got %h expected 0", bus.horz_patterns); end
    checks++; if (bus.vert_patterns !== '0) begin errors++; $display("[TB] FAIL split_vert: got %h expected 0", bus.vert_patterns); end
  endtask

  task automatic test_multi_hit();
    logic [W-1:0] expH;
    clearFrame();
    setRow(9, 0, 1);  setRow(9, 2, 3);  setRow(9, 6, 1);
    setRow(9, 12, 1); setRow(9, 14, 3); setRow(9, 18, 1);
    runScan(0);
    expH = '0; expH[3] = 1'b1; expH[15] = 1'b1;
    checks++; if (bus.horz_patterns !== expH) begin errors++; $display("[TB] FAIL multi_horz: got %h expected %h", bus.horz_patterns, expH); end
    checks++; if (bus.vert_patterns !== '0) begin errors++; $display("[TB] FAIL multi_vert: got %h expected 0", bus.vert_patterns); end
  endtask

  task automatic test_back_to_back();
    clearFrame();
    runScan(0);
    checks++; if (bus.horz_patterns !== '0) begin errors++; $display("[TB] FAIL b2b_clear_horz: got %h expected 0", bus.horz_patterns); end
    checks++; if (validCycle != 2055) begin errors++; $display("[TB] FAIL b2b_valid_cycle: got %0d expected 2055", validCycle); end
  endtask

  task automatic test_reset_mid_scan();
    logic [W-1:0] expH;
    clearFrame();
    setRow(0, 3, 1); setRow(0, 5, 3); setRow(0, 9, 1);
    expH = '0; expH[6] = 1'b1;
    startPulse();
    repeat (498) @(posedge clk_in);
    @(negedge clk_in);
    checks++; if (bus.horz_patterns !== expH) begin errors++; $display("[TB] FAIL mid_horz: got %h expected %h", bus.horz_patterns, expH); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 1", bus.busy); end
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checks++; if (bus.horz_patterns !== '0) begin errors++; $display("[TB] FAIL rst_horz: got %h expected 0", bus.horz_patterns); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.address_reading !== 20'd0) begin errors++; $display("[TB] FAIL rst_addr: got %0d expected 0", bus.address_reading); end
    checks++; if (bus.patterns_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.patterns_valid); end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_stays_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] expH;
    clearFrame();
    setRow(5, 3, 1); setRow(5, 5, 3); setRow(5, 9, 1);
    runScan(100);
    expH = '0; expH[6] = 1'b1;
    checks++; if (validCycle != 2055) begin errors++; $display("[TB] FAIL ign_valid_cycle: got %0d expected 2055", validCycle); end
    checks++; if (validCount != 1) begin errors++; $display("[TB] FAIL ign_valid_count: got %0d expected 1", validCount); end
    checks++; if (bus.horz_patterns !== expH) begin errors++; $display("[TB] FAIL ign_horz: got %h expected %h", bus.horz_patterns, expH); end
  endtask

  initial begin
    bus.start_scan = 1'b0;
    clearFrame();
    test_reset();
    test_all_white();
    test_row_pattern();
    test_col_pattern();
    test_finder();
    test_ratio_limits();
    test_line_end();
    test_multi_hit();
    test_back_to_back();
    test_reset_mid_scan();
    test_ignored_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
